rd_req_master_encode: RTL
=========================

Name: rd_req_master_encode

Overview:
- Request-side counterpart of the read-data master decoder. N upstream masters issue read requests; each request is steered to one of M downstream cache channels.
- Per-channel round-robin arbitration runs among masters targeting that channel.
- The winner's index is stamped into txnid.master_id, so returning read data routes back to the right master.
- Each channel output is a one-entry registered slice with valid/ready.

Parameters:
- N, 16, number of upstream masters (request inputs).
- M, 8, number of downstream channels (request outputs).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  [N-1:0]  request valid per master
- in_rdy  output  [N-1:0]  request accepted this cycle, per master
- in_pld  input  us_req_pld_t [N-1:0]  request payload (vector_cache_pkg)
- in_dst  input  [$clog2(M)-1:0] [N-1:0]  target channel per master
- out_vld  output  [M-1:0]  request valid per channel
- out_rdy  input  [M-1:0]  channel accepts request
- out_pld  output  us_req_pld_t [M-1:0]  request payload per channel, master_id stamped

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: out_vld=0, out_pld='0, all RR pointers=0. in_rdy is combinational and is 0 while out_vld is 0 and in_vld is 0.
- Requesters of channel j: req_j[i] = in_vld[i] && in_dst[i]==j.
- Slot free condition: slot_free_j = !out_vld[j] || out_rdy[j].
- Grant:
  - If slot_free_j and |req_j, grant the first requester at or after ptr_j, searching upward and wrapping at N-1→0.
  - in_rdy[i]=1 only for a granted master.
  - Each master targets exactly one channel, so it is granted at most once per cycle.
- Load: on grant at the next clk edge:
  - out_vld[j]←1.
  - out_pld[j]←in_pld[winner], with txnid.master_id←winner. Width is $clog2(N); upper bits are zero-extended.
  - ptr_j←(winner+1) mod N.
- Drain: if out_rdy[j] and no grant, out_vld[j]←0. out_pld is held; no clear is required.
- Hold: while out_vld[j] && !out_rdy[j]:
  - out_pld[j] stays stable.
  - No grant is issued on channel j.
  - ptr_j is unchanged.
- Throughput and latency:
  - Drain and new grant in the same cycle gives back-to-back transfers, 1 request/cycle/channel.
  - Latency is in_vld&in_rdy → out_vld exactly 1 cycle.
- Masters must hold in_vld, in_pld and in_dst stable until in_rdy. The block does not depend on this, but fairness assumes it.
- in_dst ≥ M (only possible when M is not a power of two): the request is never granted. A simulation-only assertion fires $error.
- No pointer update without a grant; idle channels keep their priority.
- Reset asserted mid-transfer: a pending out_vld drops immediately and the request is lost. Masters re-issue after reset.

Optional Feature:
- Macro RD_REQ_ENCODE_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, logic [15:0] [M-1:0].
  - stall_cnt[j] increments on each cycle where out_vld[j] && !out_rdy[j], saturating at 16'hFFFF.
  - Reset value is 0.
  - Adds input port stall_clr, 1 bit, which zeroes all counters synchronously. stall_clr takes priority over increment.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Single request: master 3 sends in_dst=2, out_rdy=all 1 → in_rdy[3]=1 same cycle; next cycle out_vld[2]=1, out_pld[2].txnid.master_id=3, other out_vld=0.
- Round-robin: masters 0, 5, 9 held valid to channel 0 with out_rdy[0]=1 → grants in order 0,5,9,0,…, one per cycle, no gaps; ptr_0 wraps correctly.
- Backpressure: out_rdy[1]=0 for 4 cycles with masters 2 and 7 pending on channel 1 → out_pld[1] stable, in_rdy[2]=in_rdy[7]=0. When out_rdy[1] rises, the next grant appears the same cycle and the transfer completes back-to-back.
- Parallel channels: 8 masters, each to a distinct channel, all valid → all in_rdy=1 in one cycle, all out_vld=1 next cycle, with correct master_id on each.
- Reset mid-operation: assert rst_n=0 while out_vld=8'hFF stalled → out_vld=0 immediately (asynchronous); after release, ptrs=0 and master 0 wins first contention.
- With RD_REQ_ENCODE_STALL_CNT_EN:
  - Stall channel 4 for 10 cycles → stall_cnt[4]=10.
  - Pulse stall_clr → 0.
  - Force 70000 stall cycles → saturates at 16'hFFFF.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// Shared request payload types for the vector cache request path.
package vector_cache_pkg;

    localparam int MASTER_ID_W = 8;

    typedef struct packed {
        logic [MASTER_ID_W-1:0] master_id;
        logic [7:0]             tag;
    } txnid_t;

    typedef struct packed {
        txnid_t      txnid;
        logic [31:0] addr;
        logic [3:0]  len;
    } us_req_pld_t;

endpackage

// File: rtl/rd_req_master_encode.sv
// Steers N master read requests onto M cache channels with per-channel round-robin, stamping master_id.
// Optional per-channel stall counters enabled by `define RD_REQ_ENCODE_STALL_CNT_EN.
module rd_req_master_encode
    import vector_cache_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int M  = 8,
    localparam int NW = (N > 1) ? $clog2(N) : 1,
    localparam int DW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_vld,
    output logic [N-1:0]         in_rdy,
    input  us_req_pld_t [N-1:0]  in_pld,
    input  logic [N-1:0][DW-1:0] in_dst,
    output logic [M-1:0]         out_vld,
    input  logic [M-1:0]         out_rdy,
    output us_req_pld_t [M-1:0]  out_pld
`ifdef RD_REQ_ENCODE_STALL_CNT_EN
    ,
    input  logic                 stall_clr,
    output logic [M-1:0][15:0]   stall_cnt
`endif
);

    logic [M-1:0]          out_vld_q, out_vld_d;
    us_req_pld_t [M-1:0]   out_pld_q, out_pld_d;
    logic [M-1:0][NW-1:0]  ptr_q, ptr_d;

    logic [M-1:0][N-1:0]   req;
    logic [M-1:0]          found;
    logic [M-1:0]          grant;
    logic [M-1:0][NW-1:0]  win;

    // (base + k) mod N, with base < N and k <= N
    function automatic logic [NW-1:0] rr_idx(input logic [NW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return NW'(s);
    endfunction

    function automatic us_req_pld_t stamp(input us_req_pld_t p, input logic [NW-1:0] id);
        us_req_pld_t r;
        r = p;
        r.txnid.master_id = '0;
        r.txnid.master_id[NW-1:0] = id;
        return r;
    endfunction

    always_comb begin
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = in_vld[i] && (int'(in_dst[i]) == j);
            end
        end
    end

    // First requester at or after ptr_q[j]; a held (stalled) slot blocks the grant
    always_comb begin
        found = '0;
        win   = '0;
        grant = '0;
        for (int j = 0; j < M; j++) begin
            for (int k = 0; k < N; k++) begin
                if (!found[j] && req[j][rr_idx(ptr_q[j], k)]) begin
                    found[j] = 1'b1;
                    win[j]   = rr_idx(ptr_q[j], k);
                end
            end
            grant[j] = found[j] && (!out_vld_q[j] || out_rdy[j]);
        end
    end

    always_comb begin
        in_rdy = '0;
        for (int j = 0; j < M; j++) begin
            if (grant[j]) in_rdy[win[j]] = 1'b1;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_pld_d = out_pld_q;
        ptr_d     = ptr_q;
        for (int j = 0; j < M; j++) begin
            if (grant[j]) begin
                out_vld_d[j] = 1'b1;
                out_pld_d[j] = stamp(in_pld[win[j]], win[j]);
                ptr_d[j]     = rr_idx(win[j], 1);
            end else if (out_rdy[j]) begin
                out_vld_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= '0;
            out_pld_q <= '0;
            ptr_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_pld_q <= out_pld_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_pld = out_pld_q;

`ifdef RD_REQ_ENCODE_STALL_CNT_EN
    logic [M-1:0][15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int j = 0; j < M; j++) begin
            if (stall_clr) begin
                stall_cnt_d[j] = '0;
            end else if (out_vld_q[j] && !out_rdy[j] && (stall_cnt_q[j] != 16'hFFFF)) begin
                stall_cnt_d[j] = stall_cnt_q[j] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // A destination beyond the last channel can never be granted
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                assert (!(in_vld[i] && (int'(in_dst[i]) >= M)))
                    else $error("rd_req_master_encode: master %0d targets channel %0d >= M", i, in_dst[i]);
            end
        end
    end
`endif

endmodule
